wide_add_sequencer: RTL and testbench

Multi-word addition sequencer that sits directly upstream and downstream of the 64-bit `pipeline_carry_select_adder`. It accepts WORDS×64-bit operands and splits them into 64-bit words, least significant first. It feeds each word pair to the adder and captures `sum`/`cout`. The captured `cout` becomes the `cin` of the next word, and the block returns one wide sum with a single-cycle `done` pulse. The adder itself is instantiated outside this block; the two connect only through the `add_*` ports.

---
 rtl/wide_add_sequencer_if.sv | 35 +++
 rtl/wide_add_sequencer.sv | 142 ++++++++++++++
 tb/tb_wide_add_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wide_add_sequencer_if.sv
// Request/response bundle for wide_add_sequencer; WORDS must match the sequencer's WORDS.
// Build option WIDE_ADD_OVF_EN adds the signed-overflow flag to the bundle.
interface wide_add_sequencer_if #(
  parameter int WORDS = 4
);
  logic                  start;
  logic [64*WORDS-1:0]   a_wide;
  logic [64*WORDS-1:0]   b_wide;
  logic                  cin_wide;
  logic                  busy;
  logic                  done;
  logic [64*WORDS-1:0]   sum_wide;
  logic                  cout_wide;
`ifdef WIDE_ADD_OVF_EN
  logic                  ovf;

  modport master (
    output start, a_wide, b_wide, cin_wide,
    input  busy, done, sum_wide, cout_wide, ovf
  );
  modport slave (
    input  start, a_wide, b_wide, cin_wide,
    output busy, done, sum_wide, cout_wide, ovf
  );
`else
  modport master (
    output start, a_wide, b_wide, cin_wide,
    input  busy, done, sum_wide, cout_wide
  );
  modport slave (
    input  start, a_wide, b_wide, cin_wide,
    output busy, done, sum_wide, cout_wide
  );
`endif
endinterface

// File: rtl/wide_add_sequencer.sv
// Splits a WORDS x 64-bit add into word-serial passes through an external ADD_LAT-deep 64-bit adder.
// Build option WIDE_ADD_OVF_EN adds a signed-overflow output (bus.ovf) updated with sum_wide.
module wide_add_sequencer #(
  parameter int WORDS   = 4,
  parameter int ADD_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  wide_add_sequencer_if.slave bus,
  output logic [63:0]         add_a,
  output logic [63:0]         add_b,
  output logic                add_cin,
  input  logic [63:0]         add_sum,
  input  logic                add_cout
);

  localparam int W     = 64 * WORDS;
  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = $clog2(ADD_LAT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ADD_LAT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_nxt;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [63:0]      add_a_q, add_a_d;
  logic [63:0]      add_b_q, add_b_d;
  logic             add_cin_q, add_cin_d;
`ifdef WIDE_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  assign idx_nxt = idx_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    add_cin_d = add_cin_q;
`ifdef WIDE_ADD_OVF_EN
    ovf_d     = ovf_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          a_d       = bus.a_wide;
          b_d       = bus.b_wide;
          add_a_d   = bus.a_wide[63:0];
          add_b_d   = bus.b_wide[63:0];
          add_cin_d = bus.cin_wide;
          cnt_d     = CNT_LOAD;
          idx_d     = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          acc_d[{idx_q, 6'b0} +: 64] = add_sum;
          if (idx_q == LAST_IDX) begin
            // acc_d already holds the top word straight from the adder
            sum_d   = acc_d;
            cout_d  = add_cout;
`ifdef WIDE_ADD_OVF_EN
            ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[63] != a_q[W-1]);
`endif
            state_d = S_DONE;
          end else begin
            add_a_d   = a_q[{idx_nxt, 6'b0} +: 64];
            add_b_d   = b_q[{idx_nxt, 6'b0} +: 64];
            add_cin_d = add_cout;
            cnt_d     = CNT_LOAD;
            idx_d     = idx_nxt;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_cin_q <= 1'b0;
`ifdef WIDE_ADD_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      add_cin_q <= add_cin_d;
`ifdef WIDE_ADD_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.sum_wide  = sum_q;
  assign bus.cout_wide = cout_q;
`ifdef WIDE_ADD_OVF_EN
  assign bus.ovf       = ovf_q;
`endif
  assign add_a   = add_a_q;
  assign add_b   = add_b_q;
  assign add_cin = add_cin_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Bench for wide_add_sequencer with a behavioural 2-edge 64-bit adder and a 257-bit golden sum.
module tb_wide_add_sequencer;
  localparam int WORDS   = 4;
  localparam int ADD_LAT = 2;
  localparam int W       = 64 * WORDS;
  localparam int OP_LAT  = WORDS * (ADD_LAT + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wide_add_sequencer_if #(.WORDS(WORDS)) bus();

  logic [63:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic [64:0] st1, st2;

  // Two-edge adder: inputs stable before edge E are visible after edge E+1, sampleable at E+2
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      st1 <= '0;
      st2 <= '0;
    end else begin
      st1 <= {1'b0, add_a} + {1'b0, add_b} + {64'd0, add_cin};
      st2 <= st1;
    end
  end
  assign add_sum  = st2[63:0];
  assign add_cout = st2[64];

  wide_add_sequencer #(.WORDS(WORDS), .ADD_LAT(ADD_LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_cin (add_cin),
    .add_sum (add_sum),
    .add_cout(add_cout)
  );

  int n_cmp    = 0;
  int n_bad    = 0;
  int done_cnt = 0;
  int exp_done = 0;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  function automatic logic [W:0] gold(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  function automatic logic gold_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] s;
    s = gold(a, b, c);
    return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Drives one request and waits (bounded) for done; lat = -1 if done never came
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       output int lat, output logic [W:0] res, output logic ovf);
    @(negedge clk);
    bus.a_wide   = a;
    bus.b_wide   = b;
    bus.cin_wide = c;
    bus.start    = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    exp_done++;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    res = {bus.cout_wide, bus.sum_wide};
`ifdef WIDE_ADD_OVF_EN
    ovf = bus.ovf;
`else
    ovf = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.a_wide = '0; bus.b_wide = '0; bus.cin_wide = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    n_cmp++; if (bus.sum_wide !== '0) begin n_bad++; $display("FAIL reset_sum got=%h exp=0", bus.sum_wide); end
    n_cmp++; if (bus.cout_wide !== 1'b0) begin n_bad++; $display("FAIL reset_cout got=%b exp=0", bus.cout_wide); end
    n_cmp++; if ({add_a, add_b, add_cin} !== '0) begin n_bad++; $display("FAIL reset_add got=%h/%h/%b exp=0", add_a, add_b, add_cin); end
`ifdef WIDE_ADD_OVF_EN
    n_cmp++; if (bus.ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_carry_ripple();
    int   lat;
    logic busy_ok;
    @(negedge clk);
    bus.a_wide = {W{1'b1}}; bus.b_wide = W'(1); bus.cin_wide = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    exp_done++;
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL ripple_busy_rise got=%b exp=1", bus.busy); end
    lat = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin lat = k; break; end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
    n_cmp++; if (lat != OP_LAT) begin n_bad++; $display("FAIL ripple_latency got=%0d exp=%0d", lat, OP_LAT); end
    n_cmp++; if (busy_ok !== 1'b1) begin n_bad++; $display("FAIL ripple_busy_held got=0 exp=1"); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL ripple_busy_fall got=%b exp=0", bus.busy); end
    n_cmp++; if ({bus.cout_wide, bus.sum_wide} !== {1'b1, {W{1'b0}}}) begin
      n_bad++; $display("FAIL ripple_sum got=%h exp=1_0", {bus.cout_wide, bus.sum_wide});
    end
    @(posedge clk);
    #1;
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL ripple_done_pulse got=%b exp=0", bus.done); end
  endtask

  task automatic test_word_carry();
    int lat; logic [W:0] res; logic ovf;
    logic [W:0] exp;
    exp = {1'b0, {(W-65){1'b0}}, 1'b1, 64'd0};
    do_op({{(W-64){1'b0}}, {64{1'b1}}}, '0, 1'b1, lat, res, ovf);
    n_cmp++; if (res !== exp) begin n_bad++; $display("FAIL word_carry got=%h exp=%h", res, exp); end
    n_cmp++; if (lat != OP_LAT) begin n_bad++; $display("FAIL word_carry_lat got=%0d exp=%0d", lat, OP_LAT); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2;
    logic c1, c2, hold_ok;
    logic [W:0] r1;
    int d1, d2;
    a1 = rand_wide(); b1 = rand_wide(); c1 = 1'(($urandom) & 1);
    a2 = rand_wide(); b2 = rand_wide(); c2 = 1'(($urandom) & 1);
    @(negedge clk);
    bus.a_wide = a1; bus.b_wide = b1; bus.cin_wide = c1; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    exp_done += 2;
    d1 = -1; d2 = -1; hold_ok = 1'b1;
    r1 = gold(a1, b1, c1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 4) begin bus.a_wide = ~a1; bus.b_wide = ~b1; bus.start = 1'b1; end
      if (k == 5) bus.start = 1'b0;
      if (k == 12) begin bus.a_wide = a2; bus.b_wide = b2; bus.cin_wide = c2; bus.start = 1'b1; end
      @(posedge clk);
      #1;
      if (k == 13) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        if (d1 < 0) d1 = k;
        else begin d2 = k; break; end
      end else if (d1 > 0 && {bus.cout_wide, bus.sum_wide} !== r1) begin
        hold_ok = 1'b0;
      end
    end
    n_cmp++; if (d1 != OP_LAT) begin n_bad++; $display("FAIL b2b_first_done got=%0d exp=%0d", d1, OP_LAT); end
    n_cmp++; if (d2 != 2 * OP_LAT + 1) begin n_bad++; $display("FAIL b2b_second_done got=%0d exp=%0d", d2, 2 * OP_LAT + 1); end
    n_cmp++; if (hold_ok !== 1'b1) begin n_bad++; $display("FAIL b2b_first_held got=0 exp=1"); end
    n_cmp++; if ({bus.cout_wide, bus.sum_wide} !== gold(a2, b2, c2)) begin
      n_bad++; $display("FAIL b2b_second_sum got=%h exp=%h", {bus.cout_wide, bus.sum_wide}, gold(a2, b2, c2));
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [W:0] res; logic ovf;
    @(negedge clk);
    bus.a_wide = rand_wide(); bus.b_wide = rand_wide(); bus.cin_wide = 1'b1; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL midrst_done got=%b exp=0", bus.done); end
    n_cmp++; if (bus.sum_wide !== '0) begin n_bad++; $display("FAIL midrst_sum got=%h exp=0", bus.sum_wide); end
    n_cmp++; if (add_a !== 64'd0) begin n_bad++; $display("FAIL midrst_add_a got=%h exp=0", add_a); end
    @(negedge clk);
    rst = 1'b0;
    do_op(W'(3), W'(4), 1'b0, lat, res, ovf);
    n_cmp++; if (res !== (W+1)'(7)) begin n_bad++; $display("FAIL midrst_after got=%h exp=7", res); end
    n_cmp++; if (lat != OP_LAT) begin n_bad++; $display("FAIL midrst_after_lat got=%0d exp=%0d", lat, OP_LAT); end
  endtask

`ifdef WIDE_ADD_OVF_EN
  task automatic test_ovf();
    int lat; logic [W:0] res; logic ovf;
    do_op({1'b0, {(W-1){1'b1}}}, W'(1), 1'b0, lat, res, ovf);
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_pos got=%b exp=1", ovf); end
    do_op({1'b1, {(W-1){1'b0}}}, {W{1'b1}}, 1'b0, lat, res, ovf);
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_neg got=%b exp=1", ovf); end
    n_cmp++; if (res[W] !== 1'b1) begin n_bad++; $display("FAIL ovf_neg_cout got=%b exp=1", res[W]); end
    do_op(W'(5), W'(6), 1'b0, lat, res, ovf);
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_none got=%b exp=0", ovf); end
  endtask
`endif

  task automatic test_random();
    int lat; logic [W:0] res; logic ovf;
    logic [W-1:0] a, b; logic c;
    for (int n = 0; n < 500; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      a = rand_wide(); b = rand_wide(); c = 1'($urandom_range(0, 1));
      if (n % 50 == 7) a = ~b;
      do_op(a, b, c, lat, res, ovf);
      n_cmp++; if (res !== gold(a, b, c) || lat != OP_LAT) begin
        n_bad++; $display("FAIL rand_%0d got=%h lat=%0d exp=%h lat=%0d", n, res, lat, gold(a, b, c), OP_LAT);
      end
`ifdef WIDE_ADD_OVF_EN
      n_cmp++; if (ovf !== gold_ovf(a, b, c)) begin n_bad++; $display("FAIL rand_ovf_%0d got=%b exp=%b", n, ovf, gold_ovf(a, b, c)); end
`endif
    end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (done_cnt != exp_done) begin n_bad++; $display("FAIL done_count got=%0d exp=%0d", done_cnt, exp_done); end
  endtask

  initial begin
    test_reset();
    test_carry_ripple();
    test_word_carry();
    test_back_to_back();
    test_reset_mid();
`ifdef WIDE_ADD_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
